clk_step_ctrl: RTL and testbench
================================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 SHALL have parameter DB_CNT, default 1000000, meaning the number of consecutive stable cycles that confirm a button level change.
REQ-002 SHALL have parameter CNT_W, default 20, meaning the debounce counter width; DB_CNT-1 SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk  input  1  system clock, the single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mode  input  2  00 halt, 01 run, 10 slow, 11 step.
REQ-006 SHALL have port slow_clk  input  1  divided-clock level from the clock divider, registered in the clk domain.
REQ-007 SHALL have port btn_step  input  1  raw, asynchronous, bouncing step button.
REQ-008 SHALL have port cpu_en  output  1  registered CPU clock-enable.
REQ-009 SHALL have port step_cnt  output  16  count of cycles with cpu_en=1.
REQ-010 SHALL have port btn_level  output  1  debounced button level.

Function
REQ-011 SHALL pass btn_step through a 2-flop synchronizer; its output is btn_s.
REQ-012 SHALL register slow_clk into slow_d each cycle; rise = slow_clk & ~slow_d; slow_clk SHALL NOT be resynchronized.
REQ-013 SHALL implement a debounce FSM with states IDLE, PRESS_WAIT, PRESSED, REL_WAIT and counter db_cnt[CNT_W-1:0].
REQ-014 SHALL, in IDLE with btn_s=1, go to PRESS_WAIT with db_cnt=0; otherwise stay in IDLE.
REQ-015 SHALL, in PRESS_WAIT with btn_s=0, return to IDLE; with btn_s=1 and db_cnt==DB_CNT-1, go to PRESSED and assert press for exactly one cycle; otherwise increment db_cnt.
REQ-016 SHALL, in PRESSED with btn_s=0, go to REL_WAIT with db_cnt=0.
REQ-017 SHALL, in REL_WAIT with btn_s=1, return to PRESSED without a press pulse; with btn_s=0 and db_cnt==DB_CNT-1, go to IDLE; otherwise increment db_cnt.
REQ-018 SHALL drive btn_level=1 in PRESSED and REL_WAIT, and 0 otherwise.
REQ-019 SHALL update cpu_en at each edge as follows: mode 00 gives 0; 01 gives 1; 10 gives rise; 11 gives press.
REQ-020 SHALL give press-to-cpu_en latency of one cycle, so cpu_en rises DB_CNT+3 edges after the first edge that samples btn_step high with no bounce.
REQ-021 SHALL assert cpu_en, in mode 10, at the same edge that first samples slow_clk=1 with slow_d=0, for exactly one cycle.
REQ-022 SHALL apply a mode change at the next edge; rise/press events occurring while not in the matching mode SHALL be discarded, never queued.
REQ-023 SHALL keep the debounce FSM and slow_d running in every mode.
REQ-024 SHALL increment step_cnt by 1 at each edge where cpu_en=1, wrapping 0xFFFF->0x0000.
REQ-025 SHALL produce at most one cpu_en pulse per debounced press and per slow_clk rising edge, regardless of how long the level is held.

Reset
REQ-026 SHALL, at an edge with rst=1, set cpu_en=0, step_cnt=0, btn_level=0, FSM=IDLE, db_cnt=0, synchronizer flops=0 and slow_d=0; rst SHALL take priority over all other inputs.
REQ-027 SHALL abort debounce on a reset mid-debounce with no press pulse; a button held through reset SHALL require a full DB_CNT stable period after rst deasserts before press asserts.
REQ-028 SHALL, when slow_clk=1 on the first edge after reset, treat it as a rise (slow_d=0).

Verification (DB_CNT=4)
REQ-029 SHALL cover: rst 3 cycles, then mode=01 -> cpu_en=1 from the first edge after rst=0; step_cnt=1,2,3,... on consecutive cycles.
REQ-030 SHALL cover: mode=10, slow_clk period 10 cycles for 5 periods -> 5 single-cycle cpu_en pulses, each at the edge that first samples slow_clk=1; step_cnt=5.
REQ-031 SHALL cover: mode=11, btn_step 1,0,1 over 3 cycles then held 1 for 12 cycles -> exactly one cpu_en pulse, DB_CNT+3 edges after the final rise; btn_level=1; step_cnt=1.
REQ-032 SHALL cover: mode=11, btn_step high for 3 cycles then low -> no cpu_en pulse; btn_level stays 0.
REQ-033 SHALL cover: mode=01 for 65536 cycles -> step_cnt wraps 0xFFFF->0x0000.
REQ-034 SHALL cover: rst=1 during PRESS_WAIT with btn_step held -> FSM=IDLE, no pulse; press asserts DB_CNT+3 edges after rst=0.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl
//
// Purpose:
//   Generates a registered clock-enable for a CPU core so it can be halted,
//   run freely, advanced once per divided-clock period, or single-stepped
//   from a bouncing push button. Also counts every enabled cycle.
//
// Parameters:
//   DB_CNT - consecutive stable cycles that confirm a button level change
//   CNT_W  - debounce counter width; DB_CNT-1 must fit in CNT_W bits
//
// Ports:
//   clk       in   1  system clock (single clock domain)
//   rst       in   1  synchronous, active-high reset
//   mode      in   2  00 halt, 01 run, 10 slow, 11 step
//   slow_clk  in   1  divided-clock level, already in the clk domain
//   btn_step  in   1  raw asynchronous step button
//   cpu_en    out  1  registered CPU clock-enable
//   step_cnt  out 16  number of cycles with cpu_en=1 (wraps)
//   btn_level out  1  debounced button level

module clk_step_ctrl #(
  parameter int DB_CNT = 1000000,
  parameter int CNT_W  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        slow_clk,
  input  logic        btn_step,
  output logic        cpu_en,
  output logic [15:0] step_cnt,
  output logic        btn_level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    REL_WAIT
  } dbState_e;

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             btnMeta_q;
  logic             btnSync_q;
  logic             slowPrev_q;
  logic             slowRise;
  dbState_e         dbState_q;
  logic [CNT_W-1:0] dbCnt_q;
  logic             press_q;
  logic             cpuEn_q;
  logic             cpuEn_d;
  logic [15:0]      stepCnt_q;
  logic [15:0]      stepCnt_d;

  // Two-flop synchronizer for the asynchronous button. slow_clk is already
  // generated in this clock domain, so it is only delayed once to find its
  // rising edge; clearing slowPrev_q on reset makes a high slow_clk on the
  // first edge after reset count as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      btnMeta_q  <= 1'b0;
      btnSync_q  <= 1'b0;
      slowPrev_q <= 1'b0;
    end else begin
      btnMeta_q  <= btn_step;
      btnSync_q  <= btnMeta_q;
      slowPrev_q <= slow_clk;
    end
  end

  assign slowRise = slow_clk & ~slowPrev_q;

  // Debounce FSM. A level change is accepted only after DB_CNT consecutive
  // samples at the new level; any bounce sends it back to the previous
  // stable state. press_q is a one-cycle pulse on entering PRESSED only, so
  // a bounce during release (REL_WAIT -> PRESSED) never re-triggers it and a
  // long hold yields a single pulse. The FSM runs in every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbState_q <= IDLE;
      dbCnt_q   <= '0;
      press_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (dbState_q)
        IDLE: begin
          if (btnSync_q) begin
            dbState_q <= PRESS_WAIT;
            dbCnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btnSync_q) begin
            dbState_q <= IDLE;
          end else if (dbCnt_q == DbLast) begin
            dbState_q <= PRESSED;
            press_q   <= 1'b1;
          end else begin
            dbCnt_q <= dbCnt_q + CntOne;
          end
        end
        PRESSED: begin
          if (!btnSync_q) begin
            dbState_q <= REL_WAIT;
            dbCnt_q   <= '0;
          end
        end
        REL_WAIT: begin
          if (btnSync_q) begin
            dbState_q <= PRESSED;
          end else if (dbCnt_q == DbLast) begin
            dbState_q <= IDLE;
          end else begin
            dbCnt_q <= dbCnt_q + CntOne;
          end
        end
        default: begin
          dbState_q <= IDLE;
          dbCnt_q   <= '0;
        end
      endcase
    end
  end

  // Enable selection. Events are consumed in the cycle they occur, so a
  // slow_clk rise or a press seen in a non-matching mode is simply lost.
  // The step counter advances on the registered enable, i.e. it counts the
  // cycles the CPU actually ran.
  always_comb begin
    cpuEn_d = 1'b0;
    case (mode)
      2'b00:   cpuEn_d = 1'b0;
      2'b01:   cpuEn_d = 1'b1;
      2'b10:   cpuEn_d = slowRise;
      2'b11:   cpuEn_d = press_q;
      default: cpuEn_d = 1'b0;
    endcase
    stepCnt_d = stepCnt_q + {15'd0, cpuEn_q};
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpuEn_q   <= 1'b0;
      stepCnt_q <= 16'd0;
    end else begin
      cpuEn_q   <= cpuEn_d;
      stepCnt_q <= stepCnt_d;
    end
  end

  assign cpu_en    = cpuEn_q;
  assign step_cnt  = stepCnt_q;
  assign btn_level = (dbState_q == PRESSED) || (dbState_q == REL_WAIT);

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl
//
// Self-checking bench for clk_step_ctrl with DB_CNT=4. Each cycle the
// stimulus task pushes the expected outputs for the coming edge onto a
// queue, then pops and compares them just after that edge. Expected
// cpu_en and btn_level come from the documented timing (button sampled at
// edge E0 -> debounced level at E0+DB+2, cpu_en pulse at E0+DB+3); the
// expected step count is accumulated from the expected cpu_en stream.

`timescale 1ns/1ps

module tb_clk_step_ctrl;

  localparam int DB = 4;
  localparam int CW = 3;

  typedef struct {
    string       tag;
    logic        cpuEn;
    logic [15:0] stepCnt;
    logic        lvl;
  } expItem_t;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        slow_clk;
  logic        btn_step;
  logic        cpu_en;
  logic [15:0] step_cnt;
  logic        btn_level;

  expItem_t    expQ[$];
  int          checkCount;
  int          errCount;
  int          pulseCount;
  logic [15:0] modelSteps;
  logic        modelCpu;

  clk_step_ctrl #(
    .DB_CNT(DB),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .slow_clk (slow_clk),
    .btn_step (btn_step),
    .cpu_en   (cpu_en),
    .step_cnt (step_cnt),
    .btn_level(btn_level)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checkCount++;
    if (obs !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, queues the expected
  // outputs for the next rising edge, and compares them 1 ns after it.
  task automatic applyStimulus(input logic rstV, input logic [1:0] modeV,
                               input logic slowV, input logic btnV,
                               input logic expCpu, input logic expLvl,
                               input string tag);
    expItem_t e;
    expItem_t got;
    @(negedge clk);
    rst      = rstV;
    mode     = modeV;
    slow_clk = slowV;
    btn_step = btnV;
    e.tag   = tag;
    e.cpuEn = expCpu;
    e.lvl   = expLvl;
    if (rstV) e.stepCnt = 16'd0;
    else      e.stepCnt = modelSteps + {15'd0, modelCpu};
    modelSteps = e.stepCnt;
    modelCpu   = rstV ? 1'b0 : expCpu;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 32'd0, 32'd1);
    end else begin
      got = expQ.pop_front();
      checkOutput({got.tag, ".cpu_en"}, {31'd0, cpu_en}, {31'd0, got.cpuEn});
      checkOutput({got.tag, ".step_cnt"}, {16'd0, step_cnt}, {16'd0, got.stepCnt});
      checkOutput({got.tag, ".btn_level"}, {31'd0, btn_level}, {31'd0, got.lvl});
    end
    if (cpu_en === 1'b1) pulseCount++;
  endtask

  initial begin
    checkCount = 0;
    errCount   = 0;
    pulseCount = 0;
    modelSteps = 16'd0;
    modelCpu   = 1'b0;
    rst        = 1'b1;
    mode       = 2'b00;
    slow_clk   = 1'b0;
    btn_step   = 1'b0;

    // Reset for 3 cycles with run mode requested: everything held at 0.
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'b01, 0, 0, 0, 0, "reset");

    // Run mode: enable from the first edge, count 0,1,2,...
    for (int i = 0; i < 5; i++) applyStimulus(0, 2'b01, 0, 0, 1, 0, "run");

    // Halt: enable drops at the next edge, count holds.
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 0, 0, 0, 0, "halt");

    // Slow mode: 5 periods of 10 cycles, one pulse per rising edge.
    pulseCount = 0;
    for (int p = 0; p < 5; p++)
      for (int c = 0; c < 10; c++)
        applyStimulus(0, 2'b10, (c >= 5), 0, (c == 5), 0, "slow");
    checkOutput("slowPulses", pulseCount, 5);

    // Slow rise while halted is discarded, not delivered after mode change.
    for (int t = 0; t < 9; t++)
      applyStimulus(0, (t < 4) ? 2'b00 : 2'b10, (t >= 2 && t != 6), 0,
                    (t == 7), 0, "slowDiscard");

    // Step mode: bounce 1,0,1 then held; final rise sampled at t=2,
    // release first sampled at t=15.
    pulseCount = 0;
    for (int t = 0; t < 25; t++)
      applyStimulus(0, 2'b11, 0, (t == 0) || (t >= 2 && t <= 14),
                    (t == 2 + DB + 3), (t >= 2 + DB + 2 && t <= 15 + DB + 1),
                    "press");
    checkOutput("pressPulses", pulseCount, 1);

    // Step mode: too short a press is rejected.
    pulseCount = 0;
    for (int t = 0; t < 12; t++)
      applyStimulus(0, 2'b11, 0, (t < 3), 0, 0, "shortPress");
    checkOutput("shortPulses", pulseCount, 0);

    // Reset during PRESS_WAIT with the button held; debounce restarts with
    // the first post-reset edge (t=5) as the sampling edge.
    pulseCount = 0;
    for (int t = 0; t < 25; t++)
      applyStimulus((t == 3 || t == 4), 2'b11, 0, (t <= 16),
                    (t == 5 + DB + 3), (t >= 5 + DB + 2 && t <= 17 + DB + 1),
                    "rstPress");
    checkOutput("rstPulses", pulseCount, 1);

    // Press completed while halted is discarded; FSM still tracks level.
    pulseCount = 0;
    for (int t = 0; t < 18; t++)
      applyStimulus(0, (t < 8) ? 2'b00 : 2'b11, 0, (t <= 9), 0,
                    (t >= DB + 2 && t <= 10 + DB + 1), "pressDiscard");
    checkOutput("discardPulses", pulseCount, 0);

    // slow_clk already high on the first edge after reset counts as a rise.
    applyStimulus(1, 2'b10, 1, 0, 0, 0, "slowRst");
    applyStimulus(0, 2'b10, 1, 0, 1, 0, "slowPostRst");
    applyStimulus(0, 2'b10, 1, 0, 0, 0, "slowHeld");
    applyStimulus(0, 2'b10, 1, 0, 0, 0, "slowHeld");

    // Long run to wrap the step counter 0xFFFF -> 0x0000.
    applyStimulus(1, 2'b01, 0, 0, 0, 0, "wrapRst");
    for (int n = 1; n <= 65538; n++)
      applyStimulus(0, 2'b01, 0, 0, 1, 0,
                    (n == 65536) ? "wrapTop" : (n == 65537) ? "wrapZero" : "wrapRun");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule
